// File: rtl/apb4_gpio_pkg.sv
// Shared definitions for the APB4 GPIO slave: register offsets, bus FSM states
// and the address decode rule.
package apb4_gpio_pkg;

  localparam logic [4:0] OFS_DATA_IN    = 5'h00;
  localparam logic [4:0] OFS_DATA_OUT   = 5'h04;
  localparam logic [4:0] OFS_DIR        = 5'h08;
  localparam logic [4:0] OFS_IRQ_EN     = 5'h0C;
  localparam logic [4:0] OFS_IRQ_TYPE   = 5'h10;
  localparam logic [4:0] OFS_IRQ_STATUS = 5'h14;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} apb_state_e;

  // Word-aligned, inside the map, and not a write to the read-only input register.
  function automatic logic ofs_ok(input logic [4:0] ofs, input logic write);
    if (ofs[1:0] != 2'b00) return 1'b0;
    if (ofs > OFS_IRQ_STATUS) return 1'b0;
    if (write && (ofs == OFS_DATA_IN)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser with history flop and per-pin rise/fall detection,
// held quiet until the pipeline has refilled after reset.
module gpio_sync_edge #(
  parameter int NUM_GPIO    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_GPIO-1:0] pin,
  output logic [NUM_GPIO-1:0] sync_val,
  output logic [NUM_GPIO-1:0] rise,
  output logic [NUM_GPIO-1:0] fall
);

  localparam logic [2:0] PRIME = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES*NUM_GPIO-1:0] chain;
  logic [NUM_GPIO-1:0]             hist;
  logic [2:0]                      prime_cnt;
  logic                            armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain     <= '0;
      hist      <= '0;
      prime_cnt <= '0;
    end else begin
      chain <= {chain[(SYNC_STAGES-1)*NUM_GPIO-1:0], pin};
      hist  <= sync_val;
      if (!armed) prime_cnt <= prime_cnt + 3'd1;
    end
  end

  always_comb begin
    sync_val = chain[SYNC_STAGES*NUM_GPIO-1 -: NUM_GPIO];
    armed    = (prime_cnt == PRIME);
    rise     = armed ? (sync_val & ~hist) : '0;
    fall     = armed ? (~sync_val & hist) : '0;
  end

endmodule

// File: rtl/apb4_gpio_slave.sv
// APB4 GPIO slave: wait-stated bus FSM, byte-strobed registers, error response
// and W1C edge interrupt status feeding a registered IRQ.
module apb4_gpio_slave
  import apb4_gpio_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_GPIO    = 32,
  parameter int WAIT_STATES = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic                    IRQ,
  input  logic [NUM_GPIO-1:0]     gpio_in,
  output logic [NUM_GPIO-1:0]     gpio_out,
  output logic [NUM_GPIO-1:0]     gpio_oe
);

  localparam logic [DATA_WIDTH-1:0] PIN_MASK = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - NUM_GPIO);

  apb_state_e state, state_next;
  logic [2:0] wcnt, wcnt_next;

  logic [DATA_WIDTH-1:0] data_out, dir, irq_en, irq_type, irq_status;
  logic [DATA_WIDTH-1:0] data_in, rise_w, fall_w, edge_hit, wmask, w1c, rd_mux;
  logic [NUM_GPIO-1:0]   sync_val, rise, fall;
  logic [4:0]            ofs;
  logic                  access_ok, wr_fire;
  logic                  unused_addr;

  assign unused_addr = ^PADDR[ADDR_WIDTH-1:5];

  gpio_sync_edge #(
    .NUM_GPIO    (NUM_GPIO),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (PCLK),
    .rst      (PRESET),
    .pin      (gpio_in),
    .sync_val (sync_val),
    .rise     (rise),
    .fall     (fall)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    case (state)
      IDLE: if (PSEL && !PENABLE) begin
        wcnt_next  = 3'(WAIT_STATES);
        state_next = (WAIT_STATES == 0) ? DONE : WAIT;
      end
      WAIT: if (!PSEL) begin
        state_next = IDLE;
        wcnt_next  = '0;
      end else if (PENABLE) begin
        if (wcnt <= 3'd1) state_next = DONE;
        wcnt_next = wcnt - 3'd1;
      end
      DONE: begin
        state_next = IDLE;
        wcnt_next  = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ofs       = PADDR[4:0];
    access_ok = ofs_ok(ofs, PWRITE);
    data_in   = '0;
    rise_w    = '0;
    fall_w    = '0;
    data_in[NUM_GPIO-1:0] = sync_val;
    rise_w[NUM_GPIO-1:0]  = rise;
    fall_w[NUM_GPIO-1:0]  = fall;
    edge_hit  = ((rise_w & ~irq_type) | (fall_w & irq_type)) & PIN_MASK;
    wmask     = '0;
    for (int unsigned b = 0; b < DATA_WIDTH/8; b++) wmask[b*8 +: 8] = {8{PSTRB[b]}};
    wr_fire   = (state == DONE) && PWRITE && access_ok;
    w1c       = (wr_fire && (ofs == OFS_IRQ_STATUS)) ? (PWDATA & wmask) : '0;
    rd_mux    = '0;
    case (ofs)
      OFS_DATA_IN:    rd_mux = data_in;
      OFS_DATA_OUT:   rd_mux = data_out;
      OFS_DIR:        rd_mux = dir;
      OFS_IRQ_EN:     rd_mux = irq_en;
      OFS_IRQ_TYPE:   rd_mux = irq_type;
      OFS_IRQ_STATUS: rd_mux = irq_status;
      default:        rd_mux = '0;
    endcase
  end

  always_comb begin
    PREADY   = (state == DONE);
    PSLVERR  = PREADY && !access_ok;
    PRDATA   = (PREADY && access_ok) ? rd_mux : '0;
    gpio_out = data_out[NUM_GPIO-1:0];
    gpio_oe  = dir[NUM_GPIO-1:0];
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      data_out   <= '0;
      dir        <= '0;
      irq_en     <= '0;
      irq_type   <= '0;
      irq_status <= '0;
      IRQ        <= 1'b0;
    end else begin
      if (wr_fire) begin
        case (ofs)
          OFS_DATA_OUT: data_out <= ((data_out & ~wmask) | (PWDATA & wmask)) & PIN_MASK;
          OFS_DIR:      dir      <= ((dir      & ~wmask) | (PWDATA & wmask)) & PIN_MASK;
          OFS_IRQ_EN:   irq_en   <= ((irq_en   & ~wmask) | (PWDATA & wmask)) & PIN_MASK;
          OFS_IRQ_TYPE: irq_type <= ((irq_type & ~wmask) | (PWDATA & wmask)) & PIN_MASK;
          default: ;
        endcase
      end
      // A fresh edge in the same cycle as its clear keeps the bit set.
      irq_status <= ((irq_status & ~w1c) | edge_hit) & PIN_MASK;
      IRQ        <= |(irq_status & irq_en);
    end
  end

endmodule
